// File: rtl/boolean_sweep_if.sv
// Bundle between the self-test control, the boolean unit and the sweep sequencer.
// The slave view belongs to the sequencer. The master view belongs to its environment.
interface boolean_sweep_if;
  logic       start;
  logic       d_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic [3:0] mismatch_cnt;
  logic       pass;

  modport master (
    output start, d_in,
    input  a_out, b_out, c_out, busy, done, truth_table, mismatch_cnt, pass
  );

  modport slave (
    input  start, d_in,
    output a_out, b_out, c_out, busy, done, truth_table, mismatch_cnt, pass
  );
endinterface

// File: rtl/boolean_sweep.sv
// Exhaustive sweep of the 3-input unit d = (~a & ~b) | ~c. The sequencer drives
// {a,b,c} = 0..7, captures d into a truth table and scores it against EXPECTED.
module boolean_sweep #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h57
) (
  input  logic           clk,
  input  logic           rst,
  boolean_sweep_if.slave bus
);

  // A settle time of zero is treated as one cycle, so every vector gets at least one cycle to propagate.
  localparam logic [3:0] SETTLE_EFF = (SETTLE_CYCLES == 0) ? 4'd1 : 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic [3:0] mismatch_cnt;
  logic       pass;

  logic       sample_miss;
  logic [3:0] mismatch_next;

  // The final sample's miss must already be in the score when pass is registered on entry to DONE.
  always_comb begin
    sample_miss   = (bus.d_in != EXPECTED[idx]);
    mismatch_next = mismatch_cnt + 4'(sample_miss);
  end

  // NOTE: sequential state uses only non-blocking assignments. Every register has an async
  // reset, so an aborted sweep leaves no partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth_table  <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= DRIVE;
            idx          <= '0;
            settle_cnt   <= SETTLE_EFF;
            busy         <= 1'b1;
            truth_table  <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end
        end

        DRIVE: begin
          // This state lasts SETTLE_EFF cycles: the count of 1 is the last one.
          if (settle_cnt <= 4'd1) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        SAMPLE: begin
          truth_table[idx] <= bus.d_in;
          mismatch_cnt     <= mismatch_next;
          if (idx == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_next == 4'd0);
          end else begin
            state      <= DRIVE;
            idx        <= idx + 3'd1;
            settle_cnt <= SETTLE_EFF;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The drive pins come straight from the index flop. After a sweep they keep the last vector (111).
  assign bus.a_out        = idx[2];
  assign bus.b_out        = idx[1];
  assign bus.c_out        = idx[0];
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.truth_table  = truth_table;
  assign bus.mismatch_cnt = mismatch_cnt;
  assign bus.pass         = pass;

endmodule

// File: tb/tb_boolean_sweep.sv
// Scoreboard bench for boolean_sweep. Expected results are queued when a sweep starts,
// and monitors compare them whenever done pulses.
module tb_boolean_sweep;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] cnt;
    logic       pass;
    int         done_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   d_mode = 0;  // 0: real unit, 1: stuck at 1, 2: stuck at 0

  sb_t q[$];
  sb_t q0[$];

  boolean_sweep_if bus ();
  boolean_sweep_if bus0 ();

  boolean_sweep dut (.clk(clk), .rst(rst), .bus(bus));
  boolean_sweep #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.d_in  = (d_mode == 0) ? ((~bus.a_out & ~bus.b_out) | ~bus.c_out) : (d_mode == 1);
  assign bus0.d_in = (~bus0.a_out & ~bus0.b_out) | ~bus0.c_out;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_result(input string tag, input sb_t e, input logic [7:0] tt,
                              input logic [3:0] cnt, input logic p);
    check({tag, "_truth_table"}, 32'(tt), 32'(e.tt));
    check({tag, "_mismatch_cnt"}, 32'(cnt), 32'(e.cnt));
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending sweep (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check_result("sweep", e, bus.truth_table, bus.mismatch_cnt, bus.pass);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (!rst && bus0.done) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_s0: got done=1 expected no pending sweep (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check_result("sweep_s0", e, bus0.truth_table, bus0.mismatch_cnt, bus0.pass);
      end
    end
  end

  // Pulse start for one cycle. On return we are at the negedge after acceptance edge e0.
  task automatic kick(output int e0);
    @(negedge clk);
    bus.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_q(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? q.size() : q0.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((which == 0) ? q.size() : q0.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done (queue %0d)", budget, which);
      if (which == 0) q.delete(); else q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_abc"}, 32'({bus.a_out, bus.b_out, bus.c_out}), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_truth_table"}, 32'(bus.truth_table), 32'd0);
    check({tag, "_mismatch_cnt"}, 32'(bus.mismatch_cnt), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
  endtask

  initial begin
    int e0;
    bus.start  = 1'b0;
    bus0.start = 1'b0;

    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Real unit with default settle: 0x57, and each vector held 3 cycles.
    kick(e0);
    q.push_back('{8'h57, 4'd0, 1'b1, e0 + 24});
    for (int k = 0; k < 24; k++) begin
      check("drive_abc", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'(k / 3));
      check("drive_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check("busy_after_last_sample", 32'(bus.busy), 32'd0);
    wait_q(0, 60);

    // d stuck at 1 and d stuck at 0.
    d_mode = 1;
    kick(e0);
    q.push_back('{8'hFF, 4'd3, 1'b0, e0 + 24});
    wait_q(0, 60);
    d_mode = 2;
    kick(e0);
    q.push_back('{8'h00, 4'd5, 1'b0, e0 + 24});
    wait_q(0, 60);
    check("held_abc", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'd7);
    check("held_mismatch_cnt", 32'(bus.mismatch_cnt), 32'd5);

    // Starts at edges 5 and 12 are ignored during a sweep.
    d_mode = 0;
    kick(e0);
    q.push_back('{8'h57, 4'd0, 1'b1, e0 + 24});
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_q(0, 60);
    repeat (30) @(negedge clk);

    // Reset at edge 10 of a sweep: everything clears and no done follows.
    kick(e0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    kick(e0);
    q.push_back('{8'h57, 4'd0, 1'b1, e0 + 24});
    wait_q(0, 60);

    // Zero settle with start held high: back-to-back sweeps.
    @(negedge clk);
    bus0.start = 1'b1;
    e0 = cyc + 1;
    q0.push_back('{8'h57, 4'd0, 1'b1, e0 + 16});
    q0.push_back('{8'h57, 4'd0, 1'b1, e0 + 34});
    repeat (18) @(negedge clk);
    check("s0_hold_truth_table", 32'(bus0.truth_table), 32'h57);
    check("s0_hold_pass", 32'(bus0.pass), 32'd1);
    check("s0_hold_abc", 32'({bus0.a_out, bus0.b_out, bus0.c_out}), 32'd7);
    check("s0_hold_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    check("s0_restart_busy", 32'(bus0.busy), 32'd1);
    check("s0_restart_truth_table", 32'(bus0.truth_table), 32'd0);
    check("s0_restart_abc", 32'({bus0.a_out, bus0.b_out, bus0.c_out}), 32'd0);
    repeat (16) @(negedge clk);
    bus0.start = 1'b0;
    wait_q(1, 40);
    repeat (5) @(negedge clk);
    check("s0_idle_busy", 32'(bus0.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
